// File: rtl/audio_mixer_if.sv
// audio_mixer_if: groups the mixer's sample-request, channel-data and status
// signals into one bundle.
//   master : sound-source / core side. Drives the strobe, channel data and
//            gains/routing, and reads back the mixed outputs and status.
//   slave  : the mixer itself.
// Signals:
//   sample_stb, clr_flags        request a mix / clear the sticky overrun flag
//   ch_l_in, ch_r_in             packed unsigned samples, channel i at [i*IN_W +: IN_W]
//   ch_gain                      packed per-channel gains, GAIN_FRAC fractional bits
//   ch_route                     packed 2-bit routing per channel (00 both, 01 L, 10 R, 11 mute)
//   AUDIO_L, AUDIO_R             saturated mix outputs
//   out_valid, busy              output update pulse / mix in progress
//   clip_l, clip_r, overrun      status flags
interface audio_mixer_if #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int GAIN_W = 5,
  parameter int OUT_W  = 16
);
  logic                     sample_stb;
  logic                     clr_flags;
  logic [NUM_CH*IN_W-1:0]   ch_l_in;
  logic [NUM_CH*IN_W-1:0]   ch_r_in;
  logic [NUM_CH*GAIN_W-1:0] ch_gain;
  logic [NUM_CH*2-1:0]      ch_route;
  logic [OUT_W-1:0]         AUDIO_L;
  logic [OUT_W-1:0]         AUDIO_R;
  logic                     out_valid;
  logic                     busy;
  logic                     clip_l;
  logic                     clip_r;
  logic                     overrun;

  modport master (
    output sample_stb, clr_flags, ch_l_in, ch_r_in, ch_gain, ch_route,
    input  AUDIO_L, AUDIO_R, out_valid, busy, clip_l, clip_r, overrun
  );

  modport slave (
    input  sample_stb, clr_flags, ch_l_in, ch_r_in, ch_gain, ch_route,
    output AUDIO_L, AUDIO_R, out_valid, busy, clip_l, clip_r, overrun
  );
endinterface

// File: rtl/audio_mixer.sv
// audio_mixer: time-multiplexed stereo mixer. On a strobe it snapshots all
// channel samples, gains and routes, accumulates one channel per clock into
// wide left/right accumulators, then drops the gain fraction and saturates
// to OUT_W bits. Latency is NUM_CH+1 clocks from the accepting edge.
// Ports:
//   clk_sys  system clock
//   reset    synchronous, active-high
//   bus      audio_mixer_if slave modport (strobe, channel data, outputs, flags)
module audio_mixer #(
  parameter int NUM_CH    = 4,
  parameter int IN_W      = 16,
  parameter int GAIN_W    = 5,
  parameter int GAIN_FRAC = 4,
  parameter int OUT_W     = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  audio_mixer_if.slave  bus
);

  localparam int PROD_W = IN_W + GAIN_W;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH + 1);
  localparam int SAT_W  = ACC_W + OUT_W;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT} state_t;

  // Drop the gain fraction (truncating) and clamp to full scale.
  // Returns {clip, value}. Done in a width that always has headroom above
  // OUT_W so the overflow test works for any parameter combination.
  function automatic logic [OUT_W:0] saturate(input logic [ACC_W-1:0] acc);
    logic [SAT_W-1:0] s;
    s = SAT_W'(acc) >> GAIN_FRAC;
    if (|(s >> OUT_W)) saturate = {1'b1, {OUT_W{1'b1}}};
    else               saturate = {1'b0, s[OUT_W-1:0]};
  endfunction

  state_t            state;
  logic [IDX_W-1:0]  idx;

  logic [IN_W-1:0]   snap_l_p0  [NUM_CH];
  logic [IN_W-1:0]   snap_r_p0  [NUM_CH];
  logic [GAIN_W-1:0] snap_g_p0  [NUM_CH];
  logic [1:0]        snap_rt_p0 [NUM_CH];

  logic [PROD_W-1:0] prod_l, prod_r;
  logic [ACC_W-1:0]  add_l, add_r;
  logic [ACC_W-1:0]  acc_l_p1, acc_r_p1;

  logic [OUT_W-1:0]  audio_l_p2, audio_r_p2;
  logic              clip_l_p2, clip_r_p2;
  logic              vld_p2;
  logic              busy_q;
  logic              overrun_q;

  logic              accept;
  logic              drop;

  assign accept = (state == S_IDLE) && bus.sample_stb;
  assign drop   = (state != S_IDLE) && bus.sample_stb;

  // ---- stage p0: snapshot of all channel inputs on an accepted strobe ----
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap_l_p0[i]  <= bus.ch_l_in[i*IN_W +: IN_W];
        snap_r_p0[i]  <= bus.ch_r_in[i*IN_W +: IN_W];
        snap_g_p0[i]  <= bus.ch_gain[i*GAIN_W +: GAIN_W];
        snap_rt_p0[i] <= bus.ch_route[i*2 +: 2];
      end
    end
  end

  // ---- stage p1: one channel per clock, gated by its route bits ----
  // route bit 1 set removes the channel from the left sum, bit 0 from the right.
  always_comb begin
    prod_l = PROD_W'(snap_l_p0[idx]) * PROD_W'(snap_g_p0[idx]);
    prod_r = PROD_W'(snap_r_p0[idx]) * PROD_W'(snap_g_p0[idx]);
    add_l  = snap_rt_p0[idx][1] ? '0 : ACC_W'(prod_l);
    add_r  = snap_rt_p0[idx][0] ? '0 : ACC_W'(prod_r);
  end

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      acc_l_p1 <= '0;
      acc_r_p1 <= '0;
    end else if (state == S_ACC) begin
      acc_l_p1 <= acc_l_p1 + add_l;
      acc_r_p1 <= acc_r_p1 + add_r;
    end
  end

  // ---- stage p2: sequencing, saturation and registered outputs ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      audio_l_p2 <= '0;
      audio_r_p2 <= '0;
      clip_l_p2  <= 1'b0;
      clip_r_p2  <= 1'b0;
      vld_p2     <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;

      // A dropped strobe beats a simultaneous clear.
      if (drop)               overrun_q <= 1'b1;
      else if (bus.clr_flags) overrun_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.sample_stb) begin
            state  <= S_ACC;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        S_ACC: begin
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) state <= S_SAT;
        end
        S_SAT: begin
          {clip_l_p2, audio_l_p2} <= saturate(acc_l_p1);
          {clip_r_p2, audio_r_p2} <= saturate(acc_r_p1);
          vld_p2 <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.AUDIO_L   = audio_l_p2;
  assign bus.AUDIO_R   = audio_r_p2;
  assign bus.clip_l    = clip_l_p2;
  assign bus.clip_r    = clip_r_p2;
  assign bus.out_valid = vld_p2;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed bench for audio_mixer with a cycle-level
// behavioural model (plain integer arithmetic over the captured channel
// data plus a busy countdown) compared against the DUT every cycle, and
// hand-computed literal expectations for each directed scenario.
module tb_audio_mixer;
  localparam int NUM_CH    = 4;
  localparam int IN_W      = 16;
  localparam int GAIN_W    = 5;
  localparam int GAIN_FRAC = 4;
  localparam int OUT_W     = 16;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  audio_mixer_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus ();

  audio_mixer #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .OUT_W(OUT_W)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void model_mix(input logic [NUM_CH*IN_W-1:0] l, input logic [NUM_CH*IN_W-1:0] r,
                                    input logic [NUM_CH*GAIN_W-1:0] g, input logic [NUM_CH*2-1:0] rt,
                                    output logic [15:0] ol, output logic [15:0] orr,
                                    output logic cl, output logic cr);
    longint sl, sr, lv, rv, gv;
    int route;
    sl = 0;
    sr = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      lv    = longint'(l[ch*IN_W +: IN_W]);
      rv    = longint'(r[ch*IN_W +: IN_W]);
      gv    = longint'(g[ch*GAIN_W +: GAIN_W]);
      route = int'(rt[ch*2 +: 2]);
      if (route == 0 || route == 1) sl += lv * gv;
      if (route == 0 || route == 2) sr += rv * gv;
    end
    sl = sl / (64'd1 << GAIN_FRAC);
    sr = sr / (64'd1 << GAIN_FRAC);
    cl  = (sl > 65535);
    cr  = (sr > 65535);
    ol  = cl ? 16'hFFFF : 16'(sl);
    orr = cr ? 16'hFFFF : 16'(sr);
  endfunction

  bit          live = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_l = '0, m_r = '0, p_l = '0, p_r = '0;
  logic        m_cl = 1'b0, m_cr = 1'b0, p_cl = 1'b0, p_cr = 1'b0;
  logic        m_vld = 1'b0, m_ovr = 1'b0;

  always @(posedge clk_sys) begin
    int          n_cnt;
    logic        n_vld, n_ovr, drop, n_cl, n_cr, a_cl, a_cr;
    logic [15:0] n_l, n_r, a_l, a_r;
    n_cnt = m_cnt; n_vld = 1'b0; n_ovr = m_ovr; drop = 1'b0;
    n_l = m_l; n_r = m_r; n_cl = m_cl; n_cr = m_cr;
    if (reset) begin
      n_cnt = 0; n_ovr = 1'b0; n_l = '0; n_r = '0; n_cl = 1'b0; n_cr = 1'b0;
    end else begin
      if (n_cnt > 0) begin
        drop = bus.sample_stb;
        n_cnt--;
        if (n_cnt == 0) begin
          n_vld = 1'b1; n_l = p_l; n_r = p_r; n_cl = p_cl; n_cr = p_cr;
        end
      end else if (bus.sample_stb) begin
        model_mix(bus.ch_l_in, bus.ch_r_in, bus.ch_gain, bus.ch_route, a_l, a_r, a_cl, a_cr);
        p_l <= a_l; p_r <= a_r; p_cl <= a_cl; p_cr <= a_cr;
        n_cnt = NUM_CH + 1;
      end
      if (drop)               n_ovr = 1'b1;
      else if (bus.clr_flags) n_ovr = 1'b0;
    end
    m_cnt <= n_cnt; m_vld <= n_vld; m_ovr <= n_ovr;
    m_l <= n_l; m_r <= n_r; m_cl <= n_cl; m_cr <= n_cr;
    if (reset) live <= 1'b1;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_sys) begin
    if (live) begin
      check("mdl_out_valid", 32'(bus.out_valid), 32'(m_vld));
      check("mdl_busy",      32'(bus.busy),      32'(m_cnt > 0));
      check("mdl_overrun",   32'(bus.overrun),   32'(m_ovr));
      check("mdl_AUDIO_L",   32'(bus.AUDIO_L),   32'(m_l));
      check("mdl_AUDIO_R",   32'(bus.AUDIO_R),   32'(m_r));
      check("mdl_clip_l",    32'(bus.clip_l),    32'(m_cl));
      check("mdl_clip_r",    32'(bus.clip_r),    32'(m_cr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_all();
    bus.ch_l_in  = '0;
    bus.ch_r_in  = '0;
    bus.ch_gain  = '0;
    bus.ch_route = '0;
  endtask

  task automatic rand_inputs();
    bus.ch_l_in  = {$urandom, $urandom};
    bus.ch_r_in  = {$urandom, $urandom};
    bus.ch_gain  = 20'($urandom);
    bus.ch_route = 8'($urandom);
  endtask

  task automatic set_ch(input int i, input logic [15:0] l, input logic [15:0] r,
                        input logic [4:0] g, input logic [1:0] rt);
    bus.ch_l_in[i*IN_W +: IN_W]       = l;
    bus.ch_r_in[i*IN_W +: IN_W]       = r;
    bus.ch_gain[i*GAIN_W +: GAIN_W]   = g;
    bus.ch_route[i*2 +: 2]            = rt;
  endtask

  // Strobe accepted at the next edge; returns just after that edge.
  task automatic strobe();
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    while (!bus.out_valid && n < maxc) begin
      tick();
      n++;
    end
    check("valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.sample_stb = 1'b0;
    bus.clr_flags  = 1'b0;
    clear_all();

    // Reset with random inputs for two edges.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      bus.sample_stb = 1'($urandom);
      bus.clr_flags  = 1'($urandom);
      tick();
    end
    reset = 1'b0;
    bus.sample_stb = 1'b0;
    bus.clr_flags  = 1'b0;
    check("rst_AUDIO_L", 32'(bus.AUDIO_L), 32'h0);
    check("rst_AUDIO_R", 32'(bus.AUDIO_R), 32'h0);
    check("rst_busy",    32'(bus.busy),    32'h0);
    check("rst_clip_l",  32'(bus.clip_l),  32'h0);
    check("rst_clip_r",  32'(bus.clip_r),  32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_valid", 32'(bus.out_valid), 32'h0);
    end

    // Unity pass-through and latency; inputs scrambled right after acceptance.
    rand_inputs();
    bus.ch_gain = '0;
    set_ch(0, 16'h1000, 16'h2000, 5'd16, 2'b00);
    strobe();
    rand_inputs();
    check("uni_busy_k", 32'(bus.busy), 32'h1);
    repeat (4) tick();
    check("uni_valid_k4", 32'(bus.out_valid), 32'h0);
    check("uni_busy_k4",  32'(bus.busy),      32'h1);
    tick();
    check("uni_valid_k5", 32'(bus.out_valid), 32'h1);
    check("uni_L",        32'(bus.AUDIO_L),   32'h1000);
    check("uni_R",        32'(bus.AUDIO_R),   32'h2000);
    check("uni_busy_k5",  32'(bus.busy),      32'h0);
    tick();
    check("uni_valid_k6", 32'(bus.out_valid), 32'h0);
    check("uni_hold_L",   32'(bus.AUDIO_L),   32'h1000);

    // Saturation, then recovery with all-zero inputs.
    clear_all();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 16'h7FFF, 16'h0000, 5'd16, 2'b00);
    strobe();
    wait_valid(10);
    check("sat_L",      32'(bus.AUDIO_L), 32'hFFFF);
    check("sat_clip_l", 32'(bus.clip_l),  32'h1);
    check("sat_R",      32'(bus.AUDIO_R), 32'h0);
    check("sat_clip_r", 32'(bus.clip_r),  32'h0);
    clear_all();
    strobe();
    wait_valid(10);
    check("zero_L",      32'(bus.AUDIO_L), 32'h0);
    check("zero_clip_l", 32'(bus.clip_l),  32'h0);

    // Routing and fractional gain.
    clear_all();
    set_ch(1, 16'h0100, 16'h0100, 5'd16, 2'b01);
    set_ch(2, 16'h0800, 16'h0800, 5'd8,  2'b10);
    set_ch(3, 16'hFFFF, 16'hFFFF, 5'd16, 2'b11);
    strobe();
    wait_valid(10);
    check("rt_L", 32'(bus.AUDIO_L), 32'h0100);
    check("rt_R", 32'(bus.AUDIO_R), 32'h0400);

    // Overrun: second strobe at k+2 dropped, outputs from the k snapshot.
    tick();
    clear_all();
    set_ch(0, 16'h0040, 16'h0080, 5'd16, 2'b00);
    strobe();
    set_ch(0, 16'h1234, 16'h4321, 5'd16, 2'b00);
    tick();
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
    check("ovr_set", 32'(bus.overrun), 32'h1);
    repeat (2) tick();
    check("ovr_valid_k4", 32'(bus.out_valid), 32'h0);
    tick();
    check("ovr_valid_k5", 32'(bus.out_valid), 32'h1);
    check("ovr_L",        32'(bus.AUDIO_L),   32'h0040);
    check("ovr_R",        32'(bus.AUDIO_R),   32'h0080);
    tick();
    check("ovr_valid_k6", 32'(bus.out_valid), 32'h0);
    tick();
    check("ovr_valid_k7", 32'(bus.out_valid), 32'h0);
    check("ovr_sticky",   32'(bus.overrun),   32'h1);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    check("ovr_clr", 32'(bus.overrun), 32'h0);
    // Drop and clear in the same cycle: set wins.
    strobe();
    bus.sample_stb = 1'b1;
    bus.clr_flags  = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
    bus.clr_flags  = 1'b0;
    check("ovr_set_wins", 32'(bus.overrun), 32'h1);
    wait_valid(10);
    check("ovr2_L", 32'(bus.AUDIO_L), 32'h1234);
    tick();
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;

    // Reset mid-mix aborts; a later strobe completes normally.
    strobe();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_valid", 32'(bus.out_valid), 32'h0);
    check("rmid_L",     32'(bus.AUDIO_L),   32'h0);
    check("rmid_R",     32'(bus.AUDIO_R),   32'h0);
    check("rmid_busy",  32'(bus.busy),      32'h0);
    tick();
    strobe();
    repeat (4) tick();
    check("rmid_valid_k8", 32'(bus.out_valid), 32'h0);
    tick();
    check("rmid_valid_k9", 32'(bus.out_valid), 32'h1);
    check("rmid_L2",       32'(bus.AUDIO_L),   32'h1234);
    check("rmid_R2",       32'(bus.AUDIO_R),   32'h4321);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Parametrised, time-multiplexed stereo audio mixer that replaces the fixed combinational sum of the TIA, POKEY, YM and COVOX sources. It snapshots NUM_CH unsigned channel pairs on a sample strobe and applies a per-channel fractional gain and L/R routing. It accumulates one channel per clock, then saturates to OUT_W bits instead of wrapping. Clip and overrun status is reported. Sits between the sound sources and the core's AUDIO_L/AUDIO_R outputs.

## Interface
- NUM_CH, 4: number of input channels, at least 1.
- IN_W, 16: unsigned sample width per channel side.
- GAIN_W, 5: unsigned per-channel gain width.
- GAIN_FRAC, 4: gain fractional bits. Unity gain = 1<<GAIN_FRAC.
- OUT_W, 16: unsigned output width.
- clk_sys  in  1  system clock. One clock only; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- sample_stb  in  1  request one mix. Sampled only while idle.
- ch_l_in  in  NUM_CH*IN_W  left samples. Channel i is at bits [i*IN_W +: IN_W].
- ch_r_in  in  NUM_CH*IN_W  right samples, same packing.
- ch_gain  in  NUM_CH*GAIN_W  per-channel gain.
- ch_route  in  NUM_CH*2  per channel: 00 both sides, 01 left only, 10 right only, 11 muted.
- clr_flags  in  1  clears the sticky overrun flag.
- AUDIO_L, AUDIO_R  out  OUT_W  mixed, saturated outputs. Held between updates.
- out_valid  out  1  one-cycle pulse when the outputs update.
- busy  out  1  mix in progress.
- clip_l, clip_r  out  1  the last mix saturated on that side. Updated together with the outputs.
- overrun  out  1  sticky: a sample_stb was dropped.

## Operation
- States: IDLE, ACC, SAT.
- IDLE:
  - sample_stb=1 copies ch_l_in, ch_r_in, ch_gain and ch_route into snapshot registers.
  - It clears acc_l and acc_r and sets idx=0, then moves to ACC.
  - Input changes after this point do not affect the mix.
- ACC, each cycle:
  - acc_l += (route[idx] is 00 or 01) ? l[idx]*gain[idx] : 0.
  - acc_r += (route[idx] is 00 or 10) ? r[idx]*gain[idx] : 0.
  - idx increments. When idx == NUM_CH-1 the state moves to SAT.
- Widths:
  - Product width is IN_W+GAIN_W.
  - Accumulator width is IN_W+GAIN_W+clog2(NUM_CH+1).
  - No intermediate overflow is possible.
- SAT:
  - s = acc >> GAIN_FRAC, truncating.
  - If s > 2^OUT_W-1, the output is 2^OUT_W-1 and the clip flag for that side is 1. Otherwise the output is s[OUT_W-1:0] and the clip flag is 0.
  - out_valid pulses, and the state returns to IDLE.
- sample_stb while in ACC or SAT is ignored and sets overrun=1.
- Overrun priority:
  - overrun stays set until clr_flags or reset.
  - If a drop and clr_flags occur in the same cycle, the set wins.
- NUM_CH=1 spends exactly one cycle in ACC.

## Timing
- Reset values: AUDIO_L=0, AUDIO_R=0, out_valid=0, busy=0, clip_l=0, clip_r=0, overrun=0, state=IDLE.
- Reset mid-mix aborts the mix with no out_valid. The snapshot contents are don't-care.
- sample_stb accepted at edge k:
  - busy=1 from after edge k through edge k+NUM_CH+1.
  - AUDIO_L, AUDIO_R, clip_l, clip_r and out_valid=1 update at edge k+NUM_CH+1.
  - out_valid returns to 0 at edge k+NUM_CH+2.
- Latency is NUM_CH+1 clocks.
- The earliest next accepted strobe is at edge k+NUM_CH+2.
- Maximum throughput is one mix per NUM_CH+2 clocks.
- busy is low in the cycle where out_valid is high, so a strobe there is accepted.
- Outputs are registered and hold their value until the next SAT.

## Test plan
All scenarios use the default parameters (NUM_CH=4, IN_W=16, GAIN_W=5, GAIN_FRAC=4, OUT_W=16).
- Reset:
  - Assert reset for 2 cycles with random inputs.
  - Expect all outputs 0 and no out_valid until a strobe.
- Unity pass-through and latency:
  - ch0 L=0x1000, R=0x2000, gain=16, route 00; other channels gain 0. Strobe at edge k.
  - Change all inputs at k+1.
  - At edge k+5: AUDIO_L=0x1000, AUDIO_R=0x2000, out_valid high for exactly 1 cycle, busy low after k+5.
- Saturation:
  - All 4 channels L=0x7FFF, gain 16, route 00.
  - Expect AUDIO_L=0xFFFF, clip_l=1.
  - Next mix with all inputs 0: AUDIO_L=0, clip_l=0.
- Routing and gain:
  - ch1 L=R=0x0100, route 01, gain 16. ch2 L=R=0x0800, route 10, gain 8. ch3 route 11, L=R=0xFFFF.
  - Expect AUDIO_L=0x0100, AUDIO_R=0x0400.
- Overrun:
  - Strobe at k and again at k+2.
  - Expect a single out_valid at k+5, overrun=1, and outputs reflecting only the k snapshot.
  - Assert clr_flags: overrun=0.
  - Drop and clr_flags in the same cycle: overrun=1.
- Reset mid-operation:
  - Strobe at k, reset at k+2.
  - Expect no out_valid, outputs 0, busy 0.
  - A strobe at k+4 then completes normally at k+9.
